// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: sequences one shared single-round datapath over Nr rounds,
// fetching round keys by index and returning the ciphertext on a ready/valid output.
module aes_round_sequencer #(
  parameter int DATA_WIDTH    = 128,
  parameter int ROUND_LATENCY = 1,
  parameter int TIMEOUT       = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_block,
  input  logic                  key_len,
  output logic [3:0]            rk_index,
  input  logic [DATA_WIDTH-1:0] rk_data,
  output logic                  rnd_valid_in,
  output logic [DATA_WIDTH-1:0] rnd_state_in,
  output logic [DATA_WIDTH-1:0] rnd_key,
  output logic                  rnd_last,
  input  logic                  rnd_valid_out,
  input  logic [DATA_WIDTH-1:0] rnd_state_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_block,
  output logic                  busy,
  output logic                  err
);

  // A timeout that could fire before a healthy round unit answers is clamped just past its latency.
  localparam int TMO    = (TIMEOUT > ROUND_LATENCY) ? TIMEOUT : ROUND_LATENCY + 1;
  localparam int WAIT_W = $clog2(TMO + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                r_fsm;
  logic [3:0]            r_round;
  logic [3:0]            r_nr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_out_valid;
  logic                  r_rnd_valid_in;
  logic                  r_rnd_last;
  logic [3:0]            r_rk_index;
  logic                  r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fsm          <= S_IDLE;
      r_round        <= 4'd0;
      r_nr           <= 4'd10;
      r_data         <= '0;
      r_wait_cnt     <= '0;
      r_in_ready     <= 1'b1;
      r_busy         <= 1'b0;
      r_out_valid    <= 1'b0;
      r_rnd_valid_in <= 1'b0;
      r_rnd_last     <= 1'b0;
      r_rk_index     <= 4'd0;
      r_err          <= 1'b0;
    end else begin
      r_rnd_valid_in <= 1'b0;
      r_err          <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            // rk_index is 0 here, so rk_data is the whitening key.
            r_data         <= in_block ^ rk_data;
            r_nr           <= key_len ? 4'd14 : 4'd10;
            r_round        <= 4'd1;
            r_rk_index     <= 4'd1;
            r_rnd_valid_in <= 1'b1;
            r_rnd_last     <= 1'b0;
            r_in_ready     <= 1'b0;
            r_busy         <= 1'b1;
            r_fsm          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= '0;
          r_fsm      <= S_WAIT;
        end
        S_WAIT: begin
          if (rnd_valid_out) begin
            r_data <= rnd_state_out;
            if (r_round == r_nr) begin
              r_out_valid <= 1'b1;
              r_fsm       <= S_DONE;
            end else begin
              r_round        <= r_round + 4'd1;
              r_rk_index     <= r_round + 4'd1;
              r_rnd_valid_in <= 1'b1;
              r_rnd_last     <= ((r_round + 4'd1) == r_nr);
              r_fsm          <= S_ISSUE;
            end
          end else if (r_wait_cnt == WAIT_W'(TMO - 1)) begin
            // TMO cycles spent waiting: abandon the block and flag it.
            r_err      <= 1'b1;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_rk_index <= 4'd0;
            r_rnd_last <= 1'b0;
            r_fsm      <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_rk_index  <= 4'd0;
            r_rnd_last  <= 1'b0;
            r_fsm       <= S_IDLE;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign out_valid    = r_out_valid;
  assign err          = r_err;
  assign rk_index     = r_rk_index;
  assign rnd_valid_in = r_rnd_valid_in;
  assign rnd_last     = r_rnd_valid_in & r_rnd_last;
  assign rnd_state_in = r_rnd_valid_in ? r_data : '0;
  assign rnd_key      = r_rnd_valid_in ? rk_data : '0;
  assign out_block    = r_data;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: key-store and round-unit models built on a behavioural AES,
// randomized blocks plus the directed latency, back-pressure, timeout and reset scenarios.
module tb_aes_round_sequencer;
  localparam int L  = 1;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, key_len;
  logic [127:0] in_block, rk_data, rnd_state_in, rnd_key, out_block;
  logic [3:0]   rk_index;
  logic         rnd_valid_in, rnd_last, out_valid, out_ready, busy, err;
  logic         rnd_valid_out = 1'b0;
  logic [127:0] rnd_state_out = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk_mem [16];
  int           drop_round  = 0;
  int           delay_round = 0;
  int           mon_issue = 0, mon_last_cnt = 0, mon_last_pos = 0;

  always #5 clk = ~clk;

  aes_round_sequencer #(.DATA_WIDTH(128), .ROUND_LATENCY(L), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .key_len(key_len), .rk_index(rk_index), .rk_data(rk_data), .rnd_valid_in(rnd_valid_in),
    .rnd_state_in(rnd_state_in), .rnd_key(rnd_key), .rnd_last(rnd_last),
    .rnd_valid_out(rnd_valid_out), .rnd_state_out(rnd_state_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy), .err(err)
  );

  assign rk_data = rk_mem[rk_index];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural AES ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, r, s;
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
      end
      s = inv;
      r = inv;
      for (int n = 0; n < 4; n++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      sbox_t[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] round_key(input logic [255:0] key, input logic kl, input int idx);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nk = kl ? 8 : 4;
    int nr = kl ? 14 : 10;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k, input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] s0, s1, s2, s3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox_t[st[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        s0 = b[4*c]; s1 = b[4*c+1]; s2 = b[4*c+2]; s3 = b[4*c+3];
        b[4*c]   = gmul(8'h02, s0) ^ gmul(8'h03, s1) ^ s2 ^ s3;
        b[4*c+1] = s0 ^ gmul(8'h02, s1) ^ gmul(8'h03, s2) ^ s3;
        b[4*c+2] = s0 ^ s1 ^ gmul(8'h02, s2) ^ gmul(8'h03, s3);
        b[4*c+3] = gmul(8'h03, s0) ^ s1 ^ s2 ^ gmul(8'h02, s3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key, input logic kl);
    int nr = kl ? 14 : 10;
    logic [127:0] s = pt ^ round_key(key, kl, 0);
    for (int r = 1; r <= nr; r++) s = aes_round(s, round_key(key, kl, r), r == nr);
    return s;
  endfunction

  // ---------------- round-unit model: responses queued with a due cycle ----------------
  typedef struct { int due; logic [127:0] d; } resp_t;
  resp_t q[$];
  int    cyc = 0;

  always @(posedge clk) begin
    int ended;
    ended = cyc;
    cyc = cyc + 1;
    if (rnd_valid_in && !(drop_round != 0 && int'(rk_index) == drop_round))
      q.push_back('{ended + L + ((delay_round != 0 && int'(rk_index) == delay_round) ? 3 : 0),
                   aes_round(rnd_state_in, rnd_key, rnd_last)});
    if (q.size() > 0 && q[0].due == cyc) begin
      rnd_valid_out <= 1'b1;
      rnd_state_out <= q[0].d;
      q.delete(0);
    end else begin
      rnd_valid_out <= 1'b0;
    end
  end

  // issue monitor: every strobe must carry the key store's entry for its ordinal round
  always @(negedge clk) begin
    if (rnd_valid_in) begin
      mon_issue++;
      check("rk_index", rk_index, mon_issue);
      check("rnd_key", rnd_key, rk_mem[mon_issue]);
      if (rnd_last) begin
        mon_last_cnt++;
        mon_last_pos = mon_issue;
      end
    end
  end

  task automatic load_keys(input logic [255:0] key, input logic kl);
    for (int i = 0; i < 16; i++) rk_mem[i] = (i <= (kl ? 14 : 10)) ? round_key(key, kl, i) : '0;
  endtask

  task automatic start_block(input logic [127:0] pt, input logic [255:0] key, input logic kl);
    load_keys(key, kl);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    if (!in_ready) check("in_ready_wait", 0, 1);
    in_block = pt;
    key_len = kl;
    in_valid = 1'b1;
    mon_issue = 0;
    mon_last_cnt = 0;
    mon_last_pos = 0;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic encrypt(input logic [127:0] pt, input logic [255:0] key, input logic kl,
                         input int hold, input logic [127:0] exp);
    int k = 1;
    int nr = kl ? 14 : 10;
    out_ready = (hold == 0);
    start_block(pt, key, kl);
    while (!out_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, nr*(L+1)+1);
    check("ciphertext", out_block, exp);
    check("issue_count", mon_issue, nr);
    check("last_count", mon_last_cnt, 1);
    check("last_pos", mon_last_pos, nr);
    check("ready_vs_valid", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", out_valid, 1);
      check("hold_block", out_block, exp);
      check("hold_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_block = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("final_valid", out_valid, 1);
    @(negedge clk);
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, pt2;
    logic [255:0] key, key2;
    logic         kl, kl2;
    int issue_cyc, err_cyc, errs, found;
    logic seen_ov, stale;

    build_sbox();
    for (int i = 0; i < 16; i++) rk_mem[i] = '0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_block = '0; key_len = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_rnd_valid_in", rnd_valid_in, 0);
    check("rst_rk_index", rk_index, 0);
    check("rst_out_block", out_block, 0);
    check("rst_rnd_key", rnd_key, 0);
    rst = 1'b1;
    @(negedge clk);

    // FIPS-197 vectors
    pt = 128'h00112233445566778899aabbccddeeff;
    encrypt(pt, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0, 0,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    encrypt(pt, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1, 0,
            128'h8ea2b7ca516745bfeafc49904b496089);

    // back-pressure for 5 cycles
    encrypt(pt, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1, 5,
            128'h8ea2b7ca516745bfeafc49904b496089);

    // round unit withholds round 3
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    drop_round = 3;
    start_block(pt, key, 1'b0);
    issue_cyc = -1; err_cyc = -1; errs = 0; seen_ov = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (rnd_valid_in && rk_index == 4'd3) issue_cyc = k;
      if (err) begin
        errs++;
        err_cyc = k;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
      end
      if (out_valid) seen_ov = 1'b1;
      @(negedge clk);
    end
    check("err_count", errs, 1);
    check("err_delay", err_cyc - issue_cyc, TO + 1);
    check("abort_no_out", seen_ov, 0);
    drop_round = 0;
    pt = {$urandom, $urandom, $urandom, $urandom};
    encrypt(pt, key, 1'b0, 0, aes_ref(pt, key, 1'b0));

    // reset while waiting on round 5, with a late response arriving afterwards
    delay_round = 5;
    start_block(pt, key, 1'b0);
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      if (rnd_valid_in && rk_index == 4'd5) found = 1;
      else @(negedge clk);
    end
    check("r5_issue_found", found, 1);
    @(negedge clk);
    check("r5_waiting", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst5_busy", busy, 0);
    check("rst5_in_ready", in_ready, 1);
    check("rst5_out_valid", out_valid, 0);
    stale = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (rnd_valid_out) stale = 1'b1;
      check("post_rst_idle", {busy, in_ready, out_valid}, 3'b010);
      @(negedge clk);
    end
    check("stale_seen", stale, 1);
    delay_round = 0;
    pt = {$urandom, $urandom, $urandom, $urandom};
    encrypt(pt, key, 1'b0, 0, aes_ref(pt, key, 1'b0));

    // back-to-back blocks with out_ready high
    pt  = {$urandom, $urandom, $urandom, $urandom};
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    encrypt(pt, key, 1'b1, 0, aes_ref(pt, key, 1'b1));
    encrypt(pt2, key2, 1'b0, 0, aes_ref(pt2, key2, 1'b0));

    // randomized blocks, key lengths and back-pressure
    for (int n = 0; n < 8; n++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kl  = 1'($urandom_range(0, 1));
      kl2 = 1'($urandom_range(0, 1));
      encrypt(pt, key, kl, $urandom_range(0, 3), aes_ref(pt, key, kl));
      encrypt(~pt, key, kl2, 0, aes_ref(~pt, key, kl2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
